// File: rtl/instruction_memory_if.sv
// Fetch-side bus between the PC logic and the instruction ROM.
// The master drives the byte address; the slave returns the registered word.
interface instruction_memory_if;
   logic [31:0] instructionAddress;
   logic [31:0] instruction;

   modport master (
      output instructionAddress,
      input  instruction
   );

   modport slave (
      input  instructionAddress,
      output instruction
   );
endinterface

// File: rtl/instruction_memory.sv
// Read-only boot program store for the IF stage; the word is registered on the
// falling edge so the IF/ID register sees a settled value on the next rising edge.
module instruction_memory #(
   parameter int DEPTH = 256
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   instruction_memory_if.slave  bus
);

   localparam int PROGRAM_WORDS = 8;

   logic [29:0] wordIndex;
   logic        inRange;
   logic [31:0] romWord;
   logic        unusedByteOffset;

   assign wordIndex        = bus.instructionAddress[31:2];
   assign unusedByteOffset = ^bus.instructionAddress[1:0];

   // Indices at or past DEPTH read as NOP rather than aliasing back onto the program.
   assign inRange = (wordIndex < 30'(DEPTH));

   always_comb begin
      romWord = 32'h0000_0000;
      if (inRange && (wordIndex < 30'(PROGRAM_WORDS))) begin
         case (wordIndex[2:0])
            3'd0:    romWord = 32'h2008_0005;
            3'd1:    romWord = 32'h2009_000A;
            3'd2:    romWord = 32'h0109_5020;
            3'd3:    romWord = 32'hAC0A_0000;
            3'd4:    romWord = 32'h8C0B_0000;
            3'd5:    romWord = 32'h016A_6022;
            3'd6:    romWord = 32'h1180_0001;
            default: romWord = 32'h0000_0000;
         endcase
      end
   end

   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.instruction <= 32'h0000_0000;
      end else begin
         bus.instruction <= romWord;
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: reset, sequential fetch, unaligned and
// out-of-range addresses, asynchronous reset and falling-edge register behaviour.
module tb_instruction_memory;

   logic CLK = 1'b1;
   logic RST_N;
   int   checkCount = 0;
   int   passCount  = 0;

   instruction_memory_if bus ();

   instruction_memory #(.DEPTH(256)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic [31:0] programWords [8] = '{
      32'h2008_0005, 32'h2009_000A, 32'h0109_5020, 32'hAC0A_0000,
      32'h8C0B_0000, 32'h016A_6022, 32'h1180_0001, 32'h0000_0000
   };

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   // Present an address at a rising edge and settle just after the next falling edge.
   task automatic applyStimulus(input logic [31:0] address);
      @(posedge CLK);
      bus.instructionAddress = address;
      @(negedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RST_N = 1'b0;
      bus.instructionAddress = 32'h0000_0000;
      #1;
      checkOutput("reset_initial", bus.instruction, 32'h0000_0000);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         #1;
         checkOutput($sformatf("reset_hold%0d", i), bus.instruction, 32'h0000_0000);
      end

      @(posedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      #1;
      checkOutput("reset_release", bus.instruction, 32'h2008_0005);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(32'(i * 4));
         checkOutput($sformatf("seq_word%0d", i), bus.instruction, programWords[i]);
      end

      applyStimulus(32'h0000_0006);
      checkOutput("unaligned_06", bus.instruction, 32'h2009_000A);
      applyStimulus(32'h0000_000B);
      checkOutput("unaligned_0B", bus.instruction, 32'h0109_5020);

      applyStimulus(32'h0000_0020);
      checkOutput("past_program_20", bus.instruction, 32'h0000_0000);
      applyStimulus(32'h0000_0000);
      checkOutput("back_to_word0", bus.instruction, 32'h2008_0005);
      applyStimulus(32'h0000_0400);
      checkOutput("index_depth_400", bus.instruction, 32'h0000_0000);
      applyStimulus(32'h0000_0004);
      checkOutput("back_to_word1", bus.instruction, 32'h2009_000A);
      applyStimulus(32'h8000_0008);
      checkOutput("high_bit_no_alias", bus.instruction, 32'h0000_0000);
      applyStimulus(32'h0000_03FC);
      checkOutput("last_index_255", bus.instruction, 32'h0000_0000);

      applyStimulus(32'h0000_0008);
      checkOutput("pre_async_reset", bus.instruction, 32'h0109_5020);
      #2;
      RST_N = 1'b0;
      #1;
      checkOutput("async_reset_clear", bus.instruction, 32'h0000_0000);
      @(negedge CLK);
      #1;
      checkOutput("async_reset_hold", bus.instruction, 32'h0000_0000);
      @(posedge CLK);
      RST_N = 1'b1;
      bus.instructionAddress = 32'h0000_0008;
      @(negedge CLK);
      #1;
      checkOutput("async_reset_release", bus.instruction, 32'h0109_5020);

      @(posedge CLK);
      bus.instructionAddress = 32'h0000_0010;
      #1;
      checkOutput("hold_after_change1", bus.instruction, 32'h0109_5020);
      #2;
      bus.instructionAddress = 32'h0000_0014;
      #1;
      checkOutput("hold_after_change2", bus.instruction, 32'h0109_5020);
      @(negedge CLK);
      #1;
      checkOutput("last_address_wins", bus.instruction, 32'h016A_6022);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
